// File: rtl/change_dispenser_fsm.sv
// Greedy change dispenser: pays out a requested amount coin by coin (20/10/5/1) from a
// refillable per-denomination inventory, with an ack timeout on each presented coin.
module change_dispenser_fsm #(
  parameter int unsigned INIT_COUNT  = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] return_amt_i,
  input  logic       dispense_req_i,
  input  logic       coin_ack_i,
  input  logic       refill_en_i,
  input  logic [1:0] refill_denom_i,
  input  logic [5:0] refill_cnt_i,
  output logic       coin_valid_o,
  output logic [1:0] coin_denom_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [6:0] short_amt_o,
  output logic       fault_o,
  output logic [3:0] state_o
);

  localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StSelect = 4'b0010,
    StPayout = 4'b0100,
    StDone   = 4'b1000
  } state_e;

  state_e            state_q;
  logic [6:0]        remaining_q;
  logic [TmoW-1:0]   tmo_q;
  logic [5:0]        inv_q [4];
  logic [5:0]        inv_d [4];
  logic [6:0]        inv_sum [4];
  logic              coin_valid_q;
  logic [1:0]        coin_denom_q;
  logic              busy_q;
  logic              done_q;
  logic [6:0]        short_q;
  logic              fault_q;
  logic              sel_found;
  logic [1:0]        sel_denom;
  logic              ack_take;

  function automatic logic [6:0] coin_value(input logic [1:0] d);
    logic [6:0] v;
    unique case (d)
      2'd0: v = 7'd1;
      2'd1: v = 7'd5;
      2'd2: v = 7'd10;
      default: v = 7'd20;
    endcase
    return v;
  endfunction

  // Ascending scan, so the largest qualifying denomination wins.
  always_comb begin
    sel_found = 1'b0;
    sel_denom = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (inv_q[i] != 6'd0 && coin_value(2'(i)) <= remaining_q) begin
        sel_found = 1'b1;
        sel_denom = 2'(i);
      end
    end
  end

  assign ack_take = (state_q == StPayout) && coin_ack_i;

  // Refill and ack-decrement may hit the same denomination; the result saturates at 63.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      inv_sum[i] = {1'b0, inv_q[i]}
                 + ((refill_en_i && refill_denom_i == 2'(i)) ? {1'b0, refill_cnt_i} : 7'd0)
                 - ((ack_take && coin_denom_q == 2'(i)) ? 7'd1 : 7'd0);
      inv_d[i]   = (inv_sum[i] > 7'd63) ? 6'd63 : inv_sum[i][5:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      remaining_q  <= 7'd0;
      tmo_q        <= '0;
      coin_valid_q <= 1'b0;
      coin_denom_q <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 7'd0;
      fault_q      <= 1'b0;
      for (int i = 0; i < 4; i++) inv_q[i] <= 6'(INIT_COUNT);
    end else begin
      for (int i = 0; i < 4; i++) inv_q[i] <= inv_d[i];
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dispense_req_i) begin
            remaining_q <= return_amt_i;
            short_q     <= 7'd0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StSelect;
          end
        end
        StSelect: begin
          if (remaining_q == 7'd0) begin
            short_q <= 7'd0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (sel_found) begin
            coin_denom_q <= sel_denom;
            coin_valid_q <= 1'b1;
            tmo_q        <= '0;
            state_q      <= StPayout;
          end else begin
            short_q <= remaining_q;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StPayout: begin
          if (coin_ack_i) begin
            remaining_q  <= remaining_q - coin_value(coin_denom_q);
            coin_valid_q <= 1'b0;
            state_q      <= StSelect;
          end else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
            // Unacked coin is not deducted from remaining.
            coin_valid_q <= 1'b0;
            fault_q      <= 1'b1;
            short_q      <= remaining_q;
            done_q       <= 1'b1;
            state_q      <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign coin_valid_o = coin_valid_q;
  assign coin_denom_o = coin_denom_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign short_amt_o  = short_q;
  assign fault_o      = fault_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_change_dispenser_fsm.sv
// Bench for change_dispenser_fsm: directed vector table, hand-written corner sequences and
// randomized payouts checked against a transaction-level greedy-change model.
module tb_change_dispenser_fsm;

  localparam int Tmo = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] return_amt;
  logic       dispense_req;
  logic       coin_ack;
  logic       refill_en;
  logic [1:0] refill_denom;
  logic [5:0] refill_cnt;
  logic       coin_valid_o;
  logic [1:0] coin_denom_o;
  logic       busy_o;
  logic       done_o;
  logic [6:0] short_amt_o;
  logic       fault_o;
  logic [3:0] state_o;

  change_dispenser_fsm dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .return_amt_i   (return_amt),
    .dispense_req_i (dispense_req),
    .coin_ack_i     (coin_ack),
    .refill_en_i    (refill_en),
    .refill_denom_i (refill_denom),
    .refill_cnt_i   (refill_cnt),
    .coin_valid_o   (coin_valid_o),
    .coin_denom_o   (coin_denom_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .short_amt_o    (short_amt_o),
    .fault_o        (fault_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int delays [128];
  int obs_q [$];
  int exp_q [$];
  int minv [4];

  typedef struct {
    int amt; int dly; int ncoins; int shrt; int flt;
    int i1; int i5; int i10; int i20;
  } vec_t;
  vec_t vecs [7];

  function automatic int val(input int d);
    case (d)
      0: return 1;
      1: return 5;
      2: return 10;
      default: return 20;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 4; d++) minv[d] = 8;
  endtask

  task automatic set_delays(input int d);
    for (int k = 0; k < 128; k++) delays[k] = d;
  endtask

  task automatic do_refill(input int d, input int c);
    refill_en = 1'b1;
    refill_denom = 2'(d);
    refill_cnt = 6'(c);
    tick();
    refill_en = 1'b0;
    minv[d] = (minv[d] + c > 63) ? 63 : minv[d] + c;
  endtask

  task automatic chk_inv(input string tag, input int i1, input int i5, input int i10,
                         input int i20);
    chk({tag, "_inv1"}, int'(dut.inv_q[0]), i1);
    chk({tag, "_inv5"}, int'(dut.inv_q[1]), i5);
    chk({tag, "_inv10"}, int'(dut.inv_q[2]), i10);
    chk({tag, "_inv20"}, int'(dut.inv_q[3]), i20);
  endtask

  // Drives one request and answers each presented coin after delays[k] extra cycles.
  task automatic run_dispense(input int amt, output int ncoins, output int shrt,
                              output int flt, output int maxrun);
    int w;
    bit got;
    obs_q.delete();
    ncoins = 0; maxrun = 0; w = 0; got = 1'b0; shrt = -1; flt = -1;
    return_amt = 7'(amt);
    dispense_req = 1'b1;
    tick();
    dispense_req = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      if (done_o) begin
        got = 1'b1;
        shrt = int'(short_amt_o);
        flt = int'(fault_o);
        coin_ack = 1'b0;
      end else if (coin_valid_o) begin
        if (w == 0) begin
          obs_q.push_back(int'(coin_denom_o));
          ncoins++;
        end
        if (w + 1 > maxrun) maxrun = w + 1;
        coin_ack = (w == delays[ncoins-1]);
        w++;
      end else begin
        coin_ack = 1'b0;
        w = 0;
      end
      if (!got) tick();
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL dispense_budget: no done seen for amt=%0d", amt);
    end else begin
      tick();
      chk("done_one_cycle", int'(done_o), 0);
      chk("idle_after_done", int'(state_o), 1);
      chk("short_held", int'(short_amt_o), shrt);
    end
  endtask

  // Greedy reference on abstract amounts; consumes the same per-coin delay plan.
  task automatic model_dispense(input int amt, output int shrt, output int flt);
    int rem, d, k;
    rem = amt; k = 0; shrt = 0; flt = 0;
    exp_q.delete();
    while (rem > 0) begin
      d = -1;
      for (int i = 3; i >= 0; i--) begin
        if (d < 0 && val(i) <= rem && minv[i] > 0) d = i;
      end
      if (d < 0) begin
        shrt = rem;
        break;
      end
      exp_q.push_back(d);
      if (delays[k] >= Tmo) begin
        flt = 1;
        shrt = rem;
        break;
      end
      rem -= val(d);
      minv[d]--;
      k++;
    end
  endtask

  initial begin
    int nc, sh, fl, mr, esh, efl, seen;
    reset = 1'b1; return_amt = '0; dispense_req = 1'b0; coin_ack = 1'b0;
    refill_en = 1'b0; refill_denom = '0; refill_cnt = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_state", int'(state_o), 1);
    chk("rst_coin_valid", int'(coin_valid_o), 0);
    chk("rst_coin_denom", int'(coin_denom_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_short", int'(short_amt_o), 0);
    chk("rst_fault", int'(fault_o), 0);
    chk_inv("rst", 8, 8, 8, 8);

    // Directed vectors, each from a fresh reset
    vecs[0] = '{37, 0, 5, 0, 0, 6, 7, 7, 7};
    vecs[1] = '{0, 0, 0, 0, 0, 8, 8, 8, 8};
    vecs[2] = '{127, 1, 9, 0, 0, 6, 7, 8, 2};
    vecs[3] = '{20, 15, 1, 0, 0, 8, 8, 8, 7};
    vecs[4] = '{20, 16, 1, 20, 1, 8, 8, 8, 8};
    vecs[5] = '{26, 3, 3, 0, 0, 7, 7, 8, 7};
    vecs[6] = '{9, 0, 5, 0, 0, 4, 7, 8, 8};
    for (int v = 0; v < 7; v++) begin
      do_reset();
      set_delays(vecs[v].dly);
      run_dispense(vecs[v].amt, nc, sh, fl, mr);
      chk($sformatf("vec%0d_ncoins", v), nc, vecs[v].ncoins);
      chk($sformatf("vec%0d_short", v), sh, vecs[v].shrt);
      chk($sformatf("vec%0d_fault", v), fl, vecs[v].flt);
      chk($sformatf("vec%0d_valid_len", v), mr,
          (vecs[v].ncoins == 0) ? 0 : ((vecs[v].dly >= Tmo) ? Tmo : vecs[v].dly + 1));
      chk_inv($sformatf("vec%0d", v), vecs[v].i1, vecs[v].i5, vecs[v].i10, vecs[v].i20);
    end

    // Latency and ignored request while busy
    do_reset();
    return_amt = 7'd5; dispense_req = 1'b1;
    tick();
    dispense_req = 1'b0;
    chk("lat_select", int'(state_o), 2);
    chk("lat_no_valid_yet", int'(coin_valid_o), 0);
    chk("lat_busy", int'(busy_o), 1);
    tick();
    chk("lat_payout", int'(state_o), 4);
    chk("lat_valid", int'(coin_valid_o), 1);
    chk("lat_denom5", int'(coin_denom_o), 1);
    coin_ack = 1'b1; return_amt = 7'd100; dispense_req = 1'b1;
    tick();
    coin_ack = 1'b0; dispense_req = 1'b0;
    chk("ack_back_select", int'(state_o), 2);
    chk("ack_valid_low", int'(coin_valid_o), 0);
    tick();
    chk("lat_done", int'(state_o), 8);
    chk("lat_done_pulse", int'(done_o), 1);
    chk("lat_done_short", int'(short_amt_o), 0);
    tick();
    chk("lat_idle", int'(state_o), 1);
    tick();
    chk("busy_req_ignored", int'(state_o), 1);
    chk_inv("lat", 8, 7, 8, 8);

    // Zero amount: SELECT then DONE, never a coin
    return_amt = 7'd0; dispense_req = 1'b1;
    tick();
    dispense_req = 1'b0;
    chk("zero_select", int'(state_o), 2);
    tick();
    chk("zero_done", int'(state_o), 8);
    chk("zero_done_pulse", int'(done_o), 1);
    chk("zero_no_valid", int'(coin_valid_o), 0);
    tick();
    chk("zero_idle", int'(state_o), 1);

    // Reset in the middle of a payout, with a refill in the reset cycle
    do_reset();
    return_amt = 7'd30; dispense_req = 1'b1;
    tick();
    dispense_req = 1'b0;
    tick(); tick(); tick();
    chk("midrst_in_payout", int'(coin_valid_o), 1);
    reset = 1'b1; refill_en = 1'b1; refill_denom = 2'd3; refill_cnt = 6'd10;
    tick();
    reset = 1'b0; refill_en = 1'b0;
    chk("midrst_state", int'(state_o), 1);
    chk("midrst_valid", int'(coin_valid_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk_inv("midrst", 8, 8, 8, 8);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_o) seen++;
      tick();
    end
    chk("midrst_no_done", seen, 0);

    // Refill plus same-cycle ack on the 1-unit coin saturates
    do_reset();
    do_refill(0, 54);
    chk("refill_62", int'(dut.inv_q[0]), 62);
    return_amt = 7'd1; dispense_req = 1'b1;
    tick();
    dispense_req = 1'b0;
    tick();
    chk("sat_denom1", int'(coin_denom_o), 0);
    coin_ack = 1'b1; refill_en = 1'b1; refill_denom = 2'd0; refill_cnt = 6'd5;
    tick();
    coin_ack = 1'b0; refill_en = 1'b0;
    chk("sat_inv63", int'(dut.inv_q[0]), 63);
    tick(); tick();
    do_refill(2, 63);
    chk("sat_plain", int'(dut.inv_q[2]), 63);

    // Exhausted 5-coin and single 1-coin leave 6 unpaid
    do_reset();
    set_delays(0);
    for (int i = 0; i < 8; i++) run_dispense(5, nc, sh, fl, mr);
    for (int i = 0; i < 7; i++) run_dispense(1, nc, sh, fl, mr);
    run_dispense(7, nc, sh, fl, mr);
    chk("short6_ncoins", nc, 1);
    chk("short6_coin", (obs_q.size() > 0) ? obs_q[0] : -1, 0);
    chk("short6_short", sh, 6);
    chk("short6_fault", fl, 0);

    // Randomized payouts against the reference model
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0)
        do_refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)));
      for (int k = 0; k < 128; k++)
        delays[k] = ($urandom_range(0, 24) == 0) ? Tmo + int'($urandom_range(0, 3))
                                                 : int'($urandom_range(0, 3));
      return_amt = '0;
      begin
        int amt;
        amt = int'($urandom_range(0, 127));
        model_dispense(amt, esh, efl);
        run_dispense(amt, nc, sh, fl, mr);
      end
      chk($sformatf("rnd%0d_ncoins", t), nc, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        chk($sformatf("rnd%0d_coin%0d", t, i), obs_q[i], exp_q[i]);
      chk($sformatf("rnd%0d_short", t), sh, esh);
      chk($sformatf("rnd%0d_fault", t), fl, efl);
      for (int d = 0; d < 4; d++)
        chk($sformatf("rnd%0d_inv%0d", t, d), int'(dut.inv_q[d]), minv[d]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
